// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the Cpu load/store/fetch port: byte-addressed RAM, 8/16/32/48-bit
// accesses, wait-state stall via cpu_enable. Optional write protection: CPU_MEM_RESP_WR_PROTECT_EN.
module cpu_mem_responder #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 2
`ifdef CPU_MEM_RESP_WR_PROTECT_EN
  , parameter int ROM_BYTES = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [47:0] req_wdata,
  output logic        cpu_enable,
  output logic [47:0] rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic [2:0]   nbytes;
  logic [32:0]  end_addr;
  logic         range_err, prot_err, acc_err, accept;
  logic [AW-1:0] byte_idx [6];
  logic [47:0]  rd_data;
  logic [7:0]   mem [MEM_BYTES];

  always_comb begin
    case (req_size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd6;
    endcase
  end

  // End address is formed one bit wider so accesses near 2^32 cannot wrap into range.
  assign end_addr  = {1'b0, req_addr} + 33'(nbytes);
  assign range_err = end_addr > 33'(MEM_BYTES);

`ifdef CPU_MEM_RESP_WR_PROTECT_EN
  assign prot_err = req_we && ({1'b0, req_addr} < 33'(ROM_BYTES));
`else
  assign prot_err = 1'b0;
`endif

  assign acc_err = range_err | prot_err;
  assign accept  = (state == ST_IDLE) && req_valid;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 6; i++) begin
      byte_idx[i] = AW'(req_addr + 32'(i));
      if (3'(i) < nbytes)
        rd_data[8*i +: 8] = mem[byte_idx[i]];
    end
  end

  // RAM is not reset; a write commits on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we && !acc_err) begin
      for (int i = 0; i < 6; i++) begin
        if (3'(i) < nbytes)
          mem[byte_idx[i]] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (cnt <= 4'd1) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rdata    <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt      <= 4'(WAIT_STATES);
        resp_err <= acc_err;
        rdata    <= (req_we || acc_err) ? '0 : rd_data;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign cpu_enable = rst_n & ((state == ST_DONE) | ~req_valid);
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed vector table, reset/back-to-back sequences,
// and randomized accesses checked against a byte-array reference model.
module tb_cpu_mem_responder;
  localparam int WS = 2;
`ifdef CPU_MEM_RESP_WR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic valid, we, en, err;
  logic [1:0] size;
  logic [31:0] addr;
  logic [47:0] wdata, rdata;
  logic v0, we0, en0, err0;
  logic [1:0] size0;
  logic [31:0] addr0;
  logic [47:0] wdata0, rdata0;

  cpu_mem_responder #(.MEM_BYTES(4096), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_we(we), .req_size(size),
    .req_addr(addr), .req_wdata(wdata), .cpu_enable(en), .rdata(rdata), .resp_err(err));

  cpu_mem_responder #(.MEM_BYTES(4096), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_we(we0), .req_size(size0),
    .req_addr(addr0), .req_wdata(wdata0), .cpu_enable(en0), .rdata(rdata0), .resp_err(err0));

  int applied = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [4096];
  bit         known   [4096];

  typedef struct {
    bit          we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [47:0] wd;
    bit          chk_rd;
    logic [47:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: an access is n whole bytes of a flat array; faults are pure address arithmetic.
  task automatic model(input bit mwe, input logic [1:0] sz, input logic [31:0] a,
                       input logic [47:0] wd, output logic [47:0] exp,
                       output logic [47:0] mask, output bit merr);
    int n;
    longint unsigned endp;
    n = (sz == 2'd3) ? 6 : (1 << sz);
    endp = 64'(a) + 64'(n);
    merr = (endp > 64'd4096) || (PROT && mwe && (a < 32'd1024));
    exp = '0;
    mask = '1;
    if (mwe) begin
      mask = '0;
      if (!merr)
        for (int i = 0; i < n; i++) begin
          ref_mem[int'(a) + i] = wd[8*i +: 8];
          known[int'(a) + i] = 1'b1;
        end
    end else if (!merr) begin
      for (int i = 0; i < n; i++) begin
        if (known[int'(a) + i]) exp[8*i +: 8] = ref_mem[int'(a) + i];
        else mask[8*i +: 8] = 8'h00;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the DONE cycle.
  task automatic acc(input bit d0, input bit awe, input logic [1:0] sz, input logic [31:0] a,
                     input logic [47:0] wd, input bit keep,
                     output logic [47:0] rd, output logic er, output int stalls);
    bit got;
    if (d0) begin v0 = 1'b1; we0 = awe; size0 = sz; addr0 = a; wdata0 = wd; end
    else    begin valid = 1'b1; we = awe; size = sz; addr = a; wdata = wd; end
    stalls = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (d0 ? en0 : en) got = 1'b1;
      else stalls++;
    end
    if (!got) begin
      applied++;
      miscompares++;
      $display("FAIL timeout: cpu_enable stayed low %0d cycles, required 1+wait states", stalls);
    end
    rd = d0 ? rdata0 : rdata;
    er = d0 ? err0 : err;
    @(posedge clk);
    #1;
    if (!keep) begin
      if (d0) v0 = 1'b0;
      else valid = 1'b0;
    end
  endtask

  logic [47:0] rd, exp, mask, r0;
  logic        er;
  bit          merr;
  int          st;

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; we = 1'b0; size = '0; addr = '0; wdata = '0;
    v0 = 1'b0; we0 = 1'b0; size0 = '0; addr0 = '0; wdata0 = '0;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;

    tbl.push_back('{1'b1, 2'd2, 32'h500, 48'hDEADBEEF, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 32'h502, 48'h0, 1'b1, 48'h0000000000AD, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 32'h500, 48'h0, 1'b1, 48'h0000DEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 2'd1, 32'h501, 48'h0, 1'b1, 48'h00000000ADBE, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 32'h601, 48'h04030201, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 32'h605, 48'h0605, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd3, 32'h601, 48'h0, 1'b1, 48'h060504030201, 1'b0});
    tbl.push_back('{1'b1, 2'd3, 32'h700, 48'hAABBCCDDEEFF, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 32'h705, 48'h0, 1'b1, 48'h0000000000AA, 1'b0});
    tbl.push_back('{1'b0, 2'd3, 32'h700, 48'h0, 1'b1, 48'hAABBCCDDEEFF, 1'b0});
    tbl.push_back('{1'b1, 2'd1, 32'hFFE, 48'hA1B2, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b1, 2'd2, 32'hFFE, 48'h11223344, 1'b0, 48'h0, 1'b1});
    tbl.push_back('{1'b0, 2'd1, 32'hFFE, 48'h0, 1'b1, 48'h00000000A1B2, 1'b0});
    tbl.push_back('{1'b0, 2'd2, 32'hFFE, 48'h0, 1'b1, 48'h0, 1'b1});
    tbl.push_back('{1'b0, 2'd0, 32'hFFF, 48'h0, 1'b1, 48'h0000000000A1, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 32'h1000, 48'h0, 1'b1, 48'h0, 1'b1});
    tbl.push_back('{1'b0, 2'd2, 32'hFFFFFFFE, 48'h0, 1'b1, 48'h0, 1'b1});
    tbl.push_back('{1'b1, 2'd0, 32'h400, 48'h55, 1'b0, 48'h0, 1'b0});
    tbl.push_back('{1'b0, 2'd0, 32'h400, 48'h0, 1'b1, 48'h000000000055, 1'b0});

    repeat (2) @(negedge clk);
    chk("rst_enable_low", 48'(en), 48'h0);
    chk("rst_rdata", rdata, 48'h0);
    chk("rst_err", 48'(err), 48'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_enable_high", 48'(en), 48'h1);
    @(posedge clk); #1;

    foreach (tbl[v]) begin
      model(tbl[v].we, tbl[v].sz, tbl[v].a, tbl[v].wd, exp, mask, merr);
      acc(1'b0, tbl[v].we, tbl[v].sz, tbl[v].a, tbl[v].wd, 1'b0, rd, er, st);
      chk($sformatf("tbl%0d_err", v), 48'(er), 48'(tbl[v].exp_err));
      chk($sformatf("tbl%0d_stalls", v), 48'(st), 48'(1 + WS));
      if (tbl[v].chk_rd) chk($sformatf("tbl%0d_rdata", v), rd, tbl[v].exp_rd);
    end

    // Boundary below the protected region: faults only when protection is built in.
    acc(1'b0, 1'b0, 2'd0, 32'h3FF, 48'h0, 1'b0, r0, er, st);
    model(1'b1, 2'd0, 32'h3FF, 48'h55, exp, mask, merr);
    acc(1'b0, 1'b1, 2'd0, 32'h3FF, 48'h55, 1'b0, rd, er, st);
    chk("wp_3ff_err", 48'(er), 48'(PROT));
    acc(1'b0, 1'b0, 2'd0, 32'h3FF, 48'h0, 1'b0, rd, er, st);
    chk("wp_3ff_readback", rd, PROT ? r0 : 48'h55);
    chk("wp_3ff_read_err", 48'(er), 48'h0);

    // Reset in the middle of a write's wait states.
    acc(1'b0, 1'b0, 2'd2, 32'h500, 48'h0, 1'b0, rd, er, st);
    chk("pre_rst_rdata", rd, 48'hDEADBEEF);
    valid = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h800; wdata = 48'h77;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_rst_enable", 48'(en), 48'h0);
    chk("midwait_rst_rdata", rdata, 48'h0);
    chk("midwait_rst_err", 48'(err), 48'h0);
    valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model(1'b1, 2'd0, 32'h800, 48'h77, exp, mask, merr);
    acc(1'b0, 1'b0, 2'd0, 32'h800, 48'h0, 1'b0, rd, er, st);
    chk("post_rst_stalls", 48'(st), 48'(1 + WS));
    chk("post_rst_committed", rd, 48'h77);

    // req_valid dropped right after acceptance: write still completes.
    valid = 1'b1; we = 1'b1; size = 2'd1; addr = 32'h900; wdata = 48'hBEEF;
    @(posedge clk); #1 valid = 1'b0;
    model(1'b1, 2'd1, 32'h900, 48'hBEEF, exp, mask, merr);
    repeat (4) @(posedge clk);
    #1;
    acc(1'b0, 1'b0, 2'd1, 32'h900, 48'h0, 1'b0, rd, er, st);
    chk("drop_valid_write", rd, 48'hBEEF);

    // Back-to-back with req_valid held high, then the zero-wait-state instance.
    acc(1'b0, 1'b0, 2'd0, 32'h502, 48'h0, 1'b1, rd, er, st);
    chk("b2b1_stalls", 48'(st), 48'(1 + WS));
    chk("b2b1_rdata", rd, 48'hAD);
    acc(1'b0, 1'b0, 2'd0, 32'h705, 48'h0, 1'b0, rd, er, st);
    chk("b2b2_stalls", 48'(st), 48'(1 + WS));
    chk("b2b2_rdata", rd, 48'hAA);
    acc(1'b1, 1'b1, 2'd0, 32'h10, 48'h3C, 1'b1, rd, er, st);
    chk("ws0_wr_stalls", 48'(st), 48'h1);
    acc(1'b1, 1'b0, 2'd0, 32'h10, 48'h0, 1'b0, rd, er, st);
    chk("ws0_rd_stalls", 48'(st), 48'h1);
    chk("ws0_rd_rdata", rd, 48'h3C);

    for (int k = 0; k < 200; k++) begin
      logic        rwe;
      logic [1:0]  rsz;
      logic [31:0] ra;
      logic [47:0] rwd;
      int          pick;
      rwe = 1'($urandom_range(0, 1));
      rsz = 2'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      ra = $urandom;
      else if (pick == 1) ra = 32'(4088 + $urandom_range(0, 12));
      else                ra = 32'($urandom_range(1000, 1100));
      rwd = {16'($urandom), 32'($urandom)};
      model(rwe, rsz, ra, rwd, exp, mask, merr);
      acc(1'b0, rwe, rsz, ra, rwd, (k < 199) && ($urandom_range(0, 1) == 1), rd, er, st);
      chk($sformatf("rnd%0d_err", k), 48'(er), 48'(merr));
      chk($sformatf("rnd%0d_stalls", k), 48'(st), 48'(1 + WS));
      if (!rwe) chk($sformatf("rnd%0d_rdata", k), rd & mask, exp & mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
